// File: rtl/pipe_ctrl_pkg.sv
// Shared types and control-vector layout for the pipeline stall/flush controller.
// The bit positions are also consumed by the CPU top-level wiring.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int CTRL_W          = 9;
  localparam int CV_MEM_WB_CLR_N = 0;
  localparam int CV_MEM_WB_EN    = 1;
  localparam int CV_EX_MEM_CLR_N = 2;
  localparam int CV_EX_MEM_EN    = 3;
  localparam int CV_ID_EX_CLR_N  = 4;
  localparam int CV_ID_EX_EN     = 5;
  localparam int CV_IF_ID_CLR_N  = 6;
  localparam int CV_IF_ID_EN     = 7;
  localparam int CV_PC_EN        = 8;

  typedef logic [CTRL_W-1:0] ctrl_vec_t;

  // Free-running pipe: every register enabled, no clears.
  localparam ctrl_vec_t CV_RUN = '1;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID-stage sources and the EX-stage load.
// Purely combinational; shared with the forwarding unit.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_reg2reg,
  input  logic       ex_wreg,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit   = id_uses_rs && (id_rs == ex_rd);
  assign rt_hit   = id_uses_rt && (id_rt == ex_rd);
  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_reg2reg && ex_wreg && (ex_rd != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
//   state    | meaning
//   RUN      | pipe advancing; no data-memory access outstanding
//   MEM_WAIT | MEM-stage access pending; pipe frozen, wait counter running
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_wreg,
  input  logic             ex_reg2reg,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_wmem,
  input  logic             mem_reg2reg,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_clr_n,
  output logic             id_ex_en,
  output logic             id_ex_clr_n,
  output logic             ex_mem_en,
  output logic             ex_mem_clr_n,
  output logic             mem_wb_en,
  output logic             mem_wb_clr_n,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  ctrl_state_t       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic              mem_busy;
  logic              load_use;
  ctrl_vec_t         ctrl;

  assign mem_busy = (mem_wmem || mem_reg2reg) && !mem_ready;

  hazard_detect u_hazard_detect (
    .ex_reg2reg (ex_reg2reg),
    .ex_wreg    (ex_wreg),
    .ex_rd      (ex_rd),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .load_use   (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
      if (wait_d == WAIT_MAX) mem_timeout <= 1'b1;
      if (!ctrl[CV_PC_EN] && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_cnt;
    case (state_q)
      RUN: begin
        if (mem_busy) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          if (wait_cnt != WAIT_MAX) wait_d = wait_cnt + 1'b1;
        end else begin
          state_d = RUN;
          wait_d  = '0;
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Priority: reset > memory freeze > branch flush > load-use bubble.
  always_comb begin
    ctrl = CV_RUN;
    if (rst) begin
      ctrl[CV_PC_EN]        = 1'b0;
      ctrl[CV_IF_ID_CLR_N]  = 1'b0;
      ctrl[CV_ID_EX_CLR_N]  = 1'b0;
      ctrl[CV_EX_MEM_CLR_N] = 1'b0;
      ctrl[CV_MEM_WB_CLR_N] = 1'b0;
    end else if (mem_busy) begin
      // WB takes a bubble so the held MEM instruction is not written back twice.
      ctrl[CV_PC_EN]        = 1'b0;
      ctrl[CV_IF_ID_EN]     = 1'b0;
      ctrl[CV_ID_EX_EN]     = 1'b0;
      ctrl[CV_EX_MEM_EN]    = 1'b0;
      ctrl[CV_MEM_WB_CLR_N] = 1'b0;
    end else if (ex_branch_taken) begin
      ctrl[CV_IF_ID_CLR_N]  = 1'b0;
      ctrl[CV_ID_EX_CLR_N]  = 1'b0;
    end else if (load_use) begin
      ctrl[CV_PC_EN]        = 1'b0;
      ctrl[CV_IF_ID_EN]     = 1'b0;
      ctrl[CV_ID_EX_CLR_N]  = 1'b0;
    end
  end

  assign pc_en        = ctrl[CV_PC_EN];
  assign if_id_en     = ctrl[CV_IF_ID_EN];
  assign if_id_clr_n  = ctrl[CV_IF_ID_CLR_N];
  assign id_ex_en     = ctrl[CV_ID_EX_EN];
  assign id_ex_clr_n  = ctrl[CV_ID_EX_CLR_N];
  assign ex_mem_en    = ctrl[CV_EX_MEM_EN];
  assign ex_mem_clr_n = ctrl[CV_EX_MEM_CLR_N];
  assign mem_wb_en    = ctrl[CV_MEM_WB_EN];
  assign mem_wb_clr_n = ctrl[CV_MEM_WB_CLR_N];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: reset, load-use, branch flush,
// memory freeze, timeout and reset during a memory wait.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 16;

  // {pc_en, if_id_en, if_id_clr_n, id_ex_en, id_ex_clr_n, ex_mem_en, ex_mem_clr_n, mem_wb_en, mem_wb_clr_n}
  localparam logic [8:0] V_RST = 9'b010101010;
  localparam logic [8:0] V_RUN = 9'b111111111;
  localparam logic [8:0] V_LU  = 9'b001101111;
  localparam logic [8:0] V_BR  = 9'b110101111;
  localparam logic [8:0] V_FRZ = 9'b001010110;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_rd;
  logic             id_uses_rs, id_uses_rt, ex_wreg, ex_reg2reg, ex_branch_taken;
  logic             mem_wmem, mem_reg2reg, mem_ready;
  logic             pc_en, if_id_en, if_id_clr_n, id_ex_en, id_ex_clr_n;
  logic             ex_mem_en, ex_mem_clr_n, mem_wb_en, mem_wb_clr_n;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [8:0]       cv;

  int n_vec = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_wreg         (ex_wreg),
    .ex_reg2reg      (ex_reg2reg),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_wmem        (mem_wmem),
    .mem_reg2reg     (mem_reg2reg),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_clr_n     (if_id_clr_n),
    .id_ex_en        (id_ex_en),
    .id_ex_clr_n     (id_ex_clr_n),
    .ex_mem_en       (ex_mem_en),
    .ex_mem_clr_n    (ex_mem_clr_n),
    .mem_wb_en       (mem_wb_en),
    .mem_wb_clr_n    (mem_wb_clr_n),
    .mem_timeout     (mem_timeout),
    .stall_cnt       (stall_cnt)
  );

  assign cv = {pc_en, if_id_en, if_id_clr_n, id_ex_en, id_ex_clr_n,
               ex_mem_en, ex_mem_clr_n, mem_wb_en, mem_wb_clr_n};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_wreg = 1'b0; ex_reg2reg = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
    mem_wmem = 1'b0; mem_reg2reg = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    chk("rst_ctrl", 32'(cv), 32'(V_RST));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    chk("post_rst_ctrl", 32'(cv), 32'(V_RUN));
    chk("post_rst_stall", 32'(stall_cnt), 32'd0);
    chk("post_rst_tmo", 32'(mem_timeout), 32'd0);
    chk("post_rst_state", 32'(dut.state_q), 32'(RUN));

    // load-use on rs
    tick();
    ex_reg2reg = 1'b1; ex_wreg = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    #3;
    chk("lu_rs_ctrl", 32'(cv), 32'(V_LU));
    tick();
    ex_reg2reg = 1'b0;
    #3;
    chk("lu_after_ctrl", 32'(cv), 32'(V_RUN));
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // exclusions: r0 destination, unused source; then rt-only match
    tick();
    ex_reg2reg = 1'b1; ex_wreg = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    #3;
    chk("lu_r0_ctrl", 32'(cv), 32'(V_RUN));
    ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b0;
    #1;
    chk("lu_unused_rs_ctrl", 32'(cv), 32'(V_RUN));
    id_rt = 5'd5; id_uses_rt = 1'b1;
    #1;
    chk("lu_rt_ctrl", 32'(cv), 32'(V_LU));

    // branch overrides load-use
    tick();
    ex_branch_taken = 1'b1;
    #3;
    chk("br_ctrl", 32'(cv), 32'(V_BR));
    chk("br_stall_cnt", 32'(stall_cnt), 32'd2);
    tick();
    idle();
    #3;
    chk("br_after_ctrl", 32'(cv), 32'(V_RUN));
    chk("br_after_stall", 32'(stall_cnt), 32'd2);

    // 3-cycle load wait, branch raised during the freeze
    tick();
    mem_reg2reg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) ex_branch_taken = 1'b1;
      #3;
      chk("frz_ctrl", 32'(cv), 32'(V_FRZ));
      if (i == 2) chk("frz_state", 32'(dut.state_q), 32'(MEM_WAIT));
      tick();
    end
    mem_ready = 1'b1;
    #3;
    chk("rdy_branch_ctrl", 32'(cv), 32'(V_BR));
    chk("rdy_stall_cnt", 32'(stall_cnt), 32'd5);
    tick();
    idle();
    #3;
    chk("rdy_state", 32'(dut.state_q), 32'(RUN));
    chk("rdy_stall_cnt2", 32'(stall_cnt), 32'd5);
    chk("rdy_tmo", 32'(mem_timeout), 32'd0);

    // timeout with MEM_TIMEOUT=4
    tick();
    mem_wmem = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #3;
      chk("tmo_wait", 32'(mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #3;
    chk("tmo_rdy_ctrl", 32'(cv), 32'(V_RUN));
    chk("tmo_rdy_flag", 32'(mem_timeout), 32'd1);
    tick();
    idle();
    #3;
    chk("tmo_sticky", 32'(mem_timeout), 32'd1);
    chk("tmo_stall_cnt", 32'(stall_cnt), 32'd11);
    chk("tmo_state", 32'(dut.state_q), 32'(RUN));

    // mem_ready without an access is ignored
    tick();
    mem_ready = 1'b1;
    #3;
    chk("rdy_only_ctrl", 32'(cv), 32'(V_RUN));
    chk("rdy_only_stall", 32'(stall_cnt), 32'd11);

    // reset in the middle of a memory wait
    tick();
    idle();
    mem_wmem = 1'b1;
    #3;
    tick();
    #3;
    chk("rstw_state", 32'(dut.state_q), 32'(MEM_WAIT));
    chk("rstw_stall", 32'(stall_cnt), 32'd12);
    tick();
    rst = 1'b1;
    #3;
    chk("rstw_ctrl", 32'(cv), 32'(V_RST));
    tick();
    rst = 1'b0;
    mem_wmem = 1'b0;
    #3;
    chk("rstw_after_state", 32'(dut.state_q), 32'(RUN));
    chk("rstw_after_tmo", 32'(mem_timeout), 32'd0);
    chk("rstw_after_stall", 32'(stall_cnt), 32'd0);
    chk("rstw_after_ctrl", 32'(cv), 32'(V_RUN));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives en/clr_n of the four pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC enable.
- Resolves three events:
  - load-use hazards: one-cycle bubble;
  - taken branches resolved in EX: squash IF_ID and ID_EX;
  - multi-cycle data-memory accesses in MEM: freeze the pipe until mem_ready.
- Also keeps a timeout monitor and a stall-cycle counter.

Parameters:
- MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout is raised.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- id_rs  in  5  ID-stage source register 1
- id_rt  in  5  ID-stage source register 2
- id_uses_rs  in  1  ID instruction reads id_rs
- id_uses_rt  in  1  ID instruction reads id_rt
- ex_wreg  in  1  EX instruction writes the register file
- ex_reg2reg  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_branch_taken  in  1  branch/jump in EX redirects the PC
- mem_wmem  in  1  MEM-stage store
- mem_reg2reg  in  1  MEM-stage load
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC update enable
- if_id_en, if_id_clr_n  out  1 each  IF_ID hold / clear controls
- id_ex_en, id_ex_clr_n  out  1 each  ID_EX hold / clear controls
- ex_mem_en, ex_mem_clr_n  out  1 each  EX_MEM hold / clear controls
- mem_wb_en, mem_wb_clr_n  out  1 each  MEM_WB hold / clear controls
- mem_timeout  out  1  sticky timeout flag
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- Register semantics:
  - en=0 holds the register and has priority over clear.
  - en=1, clr_n=0 loads zero, i.e. a bubble.
- Default, no event: every en=1, every clr_n=1.
- Outputs are combinational from state and inputs, so control takes effect on the same edge. State, counter and flag are registered.
- rst=1:
  - all en=1, all clr_n=0, so every stage clears at the edge; pc_en=0.
  - state<=RUN, wait counter<=0, mem_timeout<=0, stall_cnt<=0.
- Event terms:
  - mem_busy = (mem_wmem | mem_reg2reg) & ~mem_ready.
  - load_use = ex_reg2reg & ex_wreg & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Priority: mem_busy > ex_branch_taken > load_use.
- mem_busy (freeze):
  - pc_en=0; IF_ID, ID_EX, EX_MEM en=0.
  - mem_wb_en=1, mem_wb_clr_n=0: bubble into WB, so no duplicate write-back.
- ex_branch_taken, no mem_busy (flush):
  - pc_en=1 to load the target.
  - IF_ID and ID_EX: en=1, clr_n=0.
  - EX_MEM and MEM_WB normal: the branch itself advances.
- load_use, no higher event:
  - pc_en=0, if_id_en=0.
  - id_ex_en=1, id_ex_clr_n=0.
  - EX_MEM and MEM_WB normal.
  - Lasts 1 cycle; next cycle the load is in MEM and load_use is false.
- A branch deferred by a freeze stays held in EX and is acted on in the first cycle after mem_ready.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_busy; wait counter<=1.
  - MEM_WAIT: stays while mem_busy, wait counter increments and saturates at MEM_TIMEOUT.
  - MEM_WAIT -> RUN on mem_ready; wait counter<=0.
- mem_ready cycle: normal advance; mem_ready=1 with no access is ignored.
- Timeout:
  - mem_timeout<=1 when the wait counter reaches MEM_TIMEOUT.
  - Sticky until rst; the freeze continues regardless.
- stall_cnt: +1 on each non-reset cycle with pc_en=0; saturates at all-ones.
- rst mid-MEM_WAIT: reset wins, controller is in RUN on the next cycle.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT};
  - REG_ZERO = 5'd0;
  - localparams for the 9-bit control-vector bit positions, also used by the top-level CPU wiring.
- Sub-module hazard_detect: purely combinational load_use compare, reused by the forwarding unit.
- Everything else stays in pipeline_hazard_ctrl.

Test Plan:
- Reset: rst=1 for 2 cycles -> all clr_n=0, all en=1, pc_en=0; after release all outputs 1, stall_cnt=0, mem_timeout=0.
- Load-use: ex_reg2reg=1, ex_wreg=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_clr_n=0; next cycle all 1; stall_cnt=1.
- Load-use exclusions:
  - ex_rd=0, or id_uses_rs=0 with id_rs match -> no stall.
  - match on id_rt only -> stall.
- Branch:
  - ex_branch_taken=1 together with load_use -> pc_en=1, if_id_clr_n=0, id_ex_clr_n=0, if_id_en=1.
  - ex_mem_clr_n=1.
- Memory wait:
  - mem_reg2reg=1, mem_ready=0 for 3 cycles then 1 -> 3 freeze cycles; ex_mem_en=0, mem_wb_clr_n=0 in each.
  - state returns to RUN; stall_cnt=3.
  - Branch asserted during the freeze flushes only after release.
- Timeout: MEM_TIMEOUT=4, mem_wmem=1, mem_ready=0 for 6 cycles -> mem_timeout=1 from the 4th wait cycle, stays 1 after mem_ready, cleared only by rst.
